// File: rtl/umd_multicycle_pkg.sv
// Shared types for the multicycle mul/div unit.
// Operator encoding follows RISC-V M-extension funct3.
package umd_pkg;

    localparam int UMD_WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/umd_multicycle_if.sv
// Request/response handshake bundle for umd_multicycle.
// slave = the arithmetic unit, master = the requester/consumer.
interface umd_multicycle_if #(
    parameter int WORD_WIDTH = umd_pkg::UMD_WORD_WIDTH
);
    logic                  valid_i;
    logic                  ready_o;
    logic [WORD_WIDTH-1:0] operand_a_i;
    logic [WORD_WIDTH-1:0] operand_b_i;
    logic [2:0]            operator_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [WORD_WIDTH-1:0] result_o;

    modport slave (
        input  valid_i, operand_a_i, operand_b_i, operator_i, ready_i,
        output ready_o, valid_o, result_o
    );

    modport master (
        output valid_i, operand_a_i, operand_b_i, operator_i, ready_i,
        input  ready_o, valid_o, result_o
    );

endinterface

// File: rtl/umd_multicycle.sv
// Radix-2 iterative multiply/divide sharing one 2W shift register
// and one adder; one iteration per CALC cycle, W iterations per op.
module umd_multicycle
    import umd_pkg::*;
#(
    parameter int WORD_WIDTH = UMD_WORD_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    umd_multicycle_if.slave bus
);

    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] STEPS = CW'(W);
    localparam logic [CW-1:0] ONE   = CW'(1);

    state_e         state_q, state_d;
    op_e            op_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   opb_q;
    logic [W-1:0]   res_q;
    logic [CW-1:0]  cnt_q;
    logic           neg_q;
    logic           skip_q;

    op_e            op_in;
    logic [W-1:0]   a_in, b_in, a_mag, b_mag, spec_res;
    logic           a_neg, b_neg, neg_in, b_zero, ovf, skip_in;

    always_comb begin
        op_in  = op_e'(bus.operator_i);
        a_in   = bus.operand_a_i;
        b_in   = bus.operand_b_i;
        a_neg  = a_in[W-1] &&
                 (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_neg  = b_in[W-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
        a_mag  = a_neg ? -a_in : a_in;
        b_mag  = b_neg ? -b_in : b_in;
        // remainder sign follows the dividend only
        neg_in = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
        b_zero = (b_in == '0);
        ovf    = (op_in == OP_DIV || op_in == OP_REM) &&
                 (a_in == {1'b1, {(W-1){1'b0}}}) && (b_in == '1);
        skip_in = op_in[2] && (b_zero || ovf);
        if (b_zero) spec_res = op_in[1] ? a_in : '1;
        else        spec_res = op_in[1] ? '0 : a_in;
    end

    logic [W:0]     add_x, add_y;
    logic           add_c;
    logic [W+1:0]   add_s;
    logic           ge;
    logic [2*W-1:0] acc_step;

    always_comb begin
        if (op_q[2]) begin
            add_x = {acc_q[2*W-1:W], acc_q[W-1]};
            add_y = ~{1'b0, opb_q};
            add_c = 1'b1;
        end else begin
            add_x = {1'b0, acc_q[2*W-1:W]};
            add_y = acc_q[0] ? {1'b0, opb_q} : '0;
            add_c = 1'b0;
        end
        add_s = {1'b0, add_x} + {1'b0, add_y} + {{(W+1){1'b0}}, add_c};
        // carry out of the W+1 bit subtract means no borrow
        ge    = add_s[W+1];
        if (op_q[2])
            acc_step = {(ge ? add_s[W-1:0] : add_x[W-1:0]),
                        acc_q[W-2:0], ge};
        else
            acc_step = {add_s[W:0], acc_q[W-1:1]};
    end

    logic [2*W-1:0] mul_res;
    logic [W-1:0]   div_raw, fin;

    always_comb begin
        mul_res = neg_q ? -acc_q : acc_q;
        div_raw = op_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
        if (skip_q)
            fin = res_q;
        else if (op_q[2])
            fin = neg_q ? -div_raw : div_raw;
        else if (op_q == OP_MUL)
            fin = mul_res[W-1:0];
        else
            fin = mul_res[2*W-1:W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.valid_i) state_d = CALC;
            CALC: if (cnt_q == '0) state_d = DONE;
            DONE: if (bus.ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_MUL;
            acc_q  <= '0;
            opb_q  <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            skip_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.valid_i) begin
                    op_q   <= op_in;
                    neg_q  <= neg_in;
                    skip_q <= skip_in;
                    res_q  <= spec_res;
                    cnt_q  <= skip_in ? '0 : STEPS;
                    acc_q  <= {{W{1'b0}}, (op_in[2] ? a_mag : b_mag)};
                    opb_q  <= op_in[2] ? b_mag : a_mag;
                end
                CALC: if (cnt_q != '0) begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q - ONE;
                end else begin
                    res_q <= fin;
                end
                DONE: if (bus.ready_i) res_q <= '0;
                default: ;
            endcase
        end
    end

    assign bus.ready_o  = (state_q == IDLE);
    assign bus.valid_o  = (state_q == DONE);
    assign bus.result_o = bus.valid_o ? res_q : '0;

endmodule

// File: tb/tb_umd_multicycle.sv
// Scoreboard bench for umd_multicycle: directed, backpressure,
// reset-abort and random cases against a 64-bit reference model.
module tb_umd_multicycle;
    import umd_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    umd_multicycle_if #(.WORD_WIDTH(W)) bus();

    umd_multicycle #(.WORD_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        int          ia, ib;
        longint      sa, sb, p;
        logic [63:0] u;
        logic        ovf;
        ia  = a;
        ib  = b;
        sa  = longint'(ia);
        sb  = longint'(ib);
        u   = {32'h0, a} * {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        e.lat = 33;
        e.res = '0;
        case (op)
            3'b000: e.res = u[31:0];
            3'b001: begin p = sa * sb; e.res = p[63:32]; end
            3'b010: begin
                p = sa * longint'({32'h0, b});
                e.res = p[63:32];
            end
            3'b011: e.res = u[63:32];
            3'b100: begin
                if (b == 0)   begin e.res = '1; e.lat = 1; end
                else if (ovf) begin e.res = a;  e.lat = 1; end
                else e.res = ia / ib;
            end
            3'b101: begin
                if (b == 0) begin e.res = '1; e.lat = 1; end
                else e.res = a / b;
            end
            3'b110: begin
                if (b == 0)   begin e.res = a;  e.lat = 1; end
                else if (ovf) begin e.res = '0; e.lat = 1; end
                else e.res = ia % ib;
            end
            default: begin
                if (b == 0) begin e.res = a; e.lat = 1; end
                else e.res = a % b;
            end
        endcase
        return e;
    endfunction

    // Caller must be away from a clock edge with the DUT in IDLE.
    task automatic exec(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r,
                        input int lat_exp, input int hold);
        exp_t        e;
        exp_t        got;
        int          lat;
        logic [31:0] held;
        bus.ready_i = (hold == 0);
        check("ready_idle", bus.ready_o, 1);
        bus.valid_i     = 1'b1;
        bus.operator_i  = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        e.res = r;
        e.lat = lat_exp;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.valid_i     = 1'b0;
        bus.operator_i  = 3'($urandom);
        bus.operand_a_i = $urandom;
        bus.operand_b_i = $urandom;
        check("busy_ready", bus.ready_o, 0);
        lat = 0;
        while (!bus.valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        got = sb_q.pop_front();
        check("latency", lat, got.lat);
        check("result", bus.result_o, got.res);
        if (hold > 0) begin
            held = bus.result_o;
            bus.valid_i = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                bus.operand_a_i = $urandom;
                check("hold_valid", bus.valid_o, 1);
                check("hold_result", bus.result_o, held);
                check("hold_ready", bus.ready_o, 0);
            end
            bus.valid_i = 1'b0;
            bus.ready_i = 1'b1;
        end
        @(posedge clk); #1;
        check("rel_valid", bus.valid_o, 0);
        check("rel_result", bus.result_o, 0);
        check("rel_ready", bus.ready_o, 1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r,
                          input int lat_exp, input int hold);
        @(negedge clk);
        exec(op, a, b, r, lat_exp, hold);
    endtask

    initial begin
        int          rises;
        logic [2:0]  op;
        logic [31:0] a, b;
        exp_t        e;
        rst             = 1'b1;
        bus.valid_i     = 1'b0;
        bus.ready_i     = 1'b1;
        bus.operand_a_i = '0;
        bus.operand_b_i = '0;
        bus.operator_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.ready_o, 1);
        check("rst_valid", bus.valid_o, 0);
        check("rst_result", bus.result_o, 0);
        @(negedge clk) rst = 1'b0;

        run_op(OP_MUL, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
        run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 33, 0);
        run_op(OP_MULHU, '1, '1, 32'hFFFF_FFFE, 33, 0);
        run_op(OP_MULHSU, '1, 32'h2, 32'hFFFF_FFFF, 33, 0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, 0);
        run_op(OP_REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, 0);
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
        run_op(OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
        run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op(OP_REM, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op(OP_DIV, 32'h8000_0000, '1, 32'h8000_0000, 1, 0);
        run_op(OP_REM, 32'h8000_0000, '1, 32'h0, 1, 0);
        run_op(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op(OP_REMU, 32'd9, 32'd0, 32'd9, 1, 0);
        run_op(OP_MULHU, '1, '1, 32'hFFFF_FFFE, 33, 10);

        // abort a DIV with reset at T+15
        @(negedge clk);
        bus.ready_i     = 1'b1;
        bus.valid_i     = 1'b1;
        bus.operator_i  = OP_DIV;
        bus.operand_a_i = 32'd1000;
        bus.operand_b_i = 32'd7;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_ready", bus.ready_o, 1);
        check("abort_valid", bus.valid_o, 0);
        check("abort_result", bus.result_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        rises = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.valid_o) rises++;
        end
        check("abort_novalid", rises, 0);
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 0);

        // accept on the first edge after reset release
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        exec(OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);

        for (int i = 0; i < 1000; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = '1; end
                2: begin
                    a = $urandom_range(0, 255);
                    b = $urandom_range(1, 15);
                end
                3: b = -($urandom_range(1, 15));
                default: ;
            endcase
            e = model(op, a, b);
            run_op(op, a, b, e.res, e.lat,
                   ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
